// File: rtl/stack_mem_sequencer_pkg.sv
// Shared codes for the stack memory sequencer: FSM slot codes, stack ops,
// slot-order tracker states and the read-return tag carried through the capture stage.
package stack_mem_sequencer_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'b00,
    SLOT_1    = 2'b01,
    SLOT_2    = 2'b10,
    SLOT_3    = 2'b11
  } slot_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_e;

  // Which slot the tracker will accept next (besides a fresh start from idle)
  typedef enum logic [1:0] {
    TRK_IDLE = 2'b00,
    TRK_EXP2 = 2'b01,
    TRK_EXP1 = 2'b10
  } trk_e;

  typedef enum logic [2:0] {
    RD_NONE  = 3'd0,
    RD_PC_LO = 3'd1,
    RD_PC_HI = 3'd2,
    RD_FLAGS = 3'd3,
    RD_POP   = 3'd4
  } rd_kind_e;

  typedef struct packed {
    rd_kind_e kind;
    logic     last;
    logic     long_seq;
  } rd_tag_t;

  localparam int RD_STAGES = 1;

endpackage

// File: rtl/stack_mem_sequencer_sp_reg.sv
// Stack pointer register: post-decrement push / pre-increment pop, modulo 2^ADDR_W.
// With STACK_BOUNDS_CHECK_EN defined, illegal moves are held and a sticky fault is raised.
module stack_mem_sequencer_sp_reg #(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'((1 << ADDR_W) - 1)
`ifdef STACK_BOUNDS_CHECK_EN
  , parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'((1 << ADDR_W) - 1024)
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_req,
  input  logic              dec_req,
  output logic [ADDR_W-1:0] sp,
  output logic              push_ok,
  output logic              pop_ok,
  output logic              fault
);

`ifdef STACK_BOUNDS_CHECK_EN
  assign push_ok = (sp >= SP_LIMIT);
  assign pop_ok  = (sp != SP_RESET);

  always_ff @(posedge clk) begin
    if (rst)
      fault <= 1'b0;
    else if ((dec_req && !push_ok) || (inc_req && !pop_ok))
      fault <= 1'b1;
  end
`else
  assign push_ok = 1'b1;
  assign pop_ok  = 1'b1;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      sp <= SP_RESET;
    else if (inc_req && pop_ok)
      sp <= sp + ADDR_W'(1);
    else if (dec_req && push_ok)
      sp <= sp - ADDR_W'(1);
  end

endmodule

// File: rtl/stack_mem_sequencer.sv
// Memory-stage stack engine: decodes FSM slots and single-cycle PUSH/POP into stack
// memory accesses and reassembles PC/flags on return. Optional macro: STACK_BOUNDS_CHECK_EN.
module stack_mem_sequencer
  import stack_mem_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int FLAGS_W = 4,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'((1 << ADDR_W) - 1)
`ifdef STACK_BOUNDS_CHECK_EN
  , parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'((1 << ADDR_W) - 1024)
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          seq_state,
  input  logic [1:0]          seq_op,
  input  logic                sp_push,
  input  logic                sp_pop,
  input  logic [2*DATA_W-1:0] pc_in,
  input  logic [FLAGS_W-1:0]  flags_in,
  input  logic [DATA_W-1:0]   reg_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  output logic [ADDR_W-1:0]   sp_out,
  output logic [2*DATA_W-1:0] pc_restore,
  output logic                pc_restore_vld,
  output logic [FLAGS_W-1:0]  flags_restore,
  output logic                flags_restore_vld,
  output logic [DATA_W-1:0]   pop_data,
  output logic                pop_data_vld,
  output logic                stack_fault
);

  slot_e   slot;
  op_e     sop, op_q, op_d;
  trk_e    trk_q, trk_d;
  logic    long_q, long_d, slot_ok;
  logic    push_req, pop_req, push_ok, pop_ok;
  rd_tag_t tag_d, tag_q;

  logic [RD_STAGES:0]   vld_pipe;
  logic [RD_STAGES-1:0] vld_q;
  logic                 rd_done;

  logic [DATA_W-1:0]  pc_lo_q, pc_hi_q, pop_q;
  logic [FLAGS_W-1:0] flags_q;

  assign slot = slot_e'(seq_state);
  assign sop  = op_e'(seq_op);

  stack_mem_sequencer_sp_reg #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
`ifdef STACK_BOUNDS_CHECK_EN
    , .SP_LIMIT (SP_LIMIT)
`endif
  ) u_sp (
    .clk     (clk),
    .rst     (rst),
    .inc_req (pop_req),
    .dec_req (push_req),
    .sp      (sp_out),
    .push_ok (push_ok),
    .pop_ok  (pop_ok),
    .fault   (stack_fault)
  );

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      trk_q  <= TRK_IDLE;
      long_q <= 1'b0;
      op_q   <= OP_NONE;
    end else begin
      trk_q  <= trk_d;
      long_q <= long_d;
      op_q   <= op_d;
    end
  end

  // Out-of-order slots are no-ops and leave the tracker where it was; idle aborts.
  always_comb begin : next_state
    trk_d   = trk_q;
    long_d  = long_q;
    op_d    = op_q;
    slot_ok = 1'b0;
    case (slot)
      SLOT_3: if (trk_q == TRK_IDLE) begin
        slot_ok = 1'b1;
        trk_d   = TRK_EXP2;
      end
      SLOT_2: if (trk_q == TRK_IDLE || trk_q == TRK_EXP2) begin
        slot_ok = 1'b1;
        trk_d   = TRK_EXP1;
      end
      SLOT_1: if (trk_q == TRK_EXP1) begin
        slot_ok = 1'b1;
        trk_d   = TRK_IDLE;
      end
      default: trk_d = TRK_IDLE;
    endcase
    if (slot_ok && trk_q == TRK_IDLE) begin
      long_d = (slot == SLOT_3);
      op_d   = sop;
    end
  end

  always_comb begin : outputs
    push_req  = 1'b0;
    pop_req   = 1'b0;
    mem_wdata = '0;
    tag_d     = '0;
    if (!rst) begin
      if (slot != SLOT_IDLE) begin
        if (slot_ok && sop != OP_NONE) begin
          if (op_d == OP_PUSH) begin
            push_req = 1'b1;
            case (slot)
              SLOT_3:  mem_wdata = {{(DATA_W-FLAGS_W){1'b0}}, flags_in};
              SLOT_2:  mem_wdata = pc_in[2*DATA_W-1:DATA_W];
              default: mem_wdata = pc_in[DATA_W-1:0];
            endcase
          end else if (op_d == OP_POP) begin
            pop_req        = 1'b1;
            tag_d.last     = (slot == SLOT_1);
            tag_d.long_seq = long_d;
            case (slot)
              SLOT_3:  tag_d.kind = RD_PC_LO;
              SLOT_2:  tag_d.kind = long_d ? RD_PC_HI : RD_PC_LO;
              default: tag_d.kind = long_d ? RD_FLAGS : RD_PC_HI;
            endcase
          end
        end
      end else if (sp_push && !sp_pop) begin
        push_req  = 1'b1;
        mem_wdata = reg_wdata;
      end else if (sp_pop && !sp_push) begin
        pop_req    = 1'b1;
        tag_d.kind = RD_POP;
      end
    end
  end

  assign mem_we   = push_req && push_ok;
  assign mem_re   = pop_req && pop_ok;
  assign mem_addr = pop_req ? sp_out + ADDR_W'(1) : sp_out;

  // Read-return stage: the tag follows mem_re by one cycle, aligned with mem_rdata.
  assign vld_pipe = {vld_q, mem_re};
  assign rd_done  = vld_pipe[RD_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      tag_q   <= '0;
      pc_lo_q <= '0;
      pc_hi_q <= '0;
      flags_q <= '0;
      pop_q   <= '0;
    end else begin
      vld_q <= vld_pipe[RD_STAGES-1:0];
      if (mem_re) tag_q <= tag_d;
      if (rd_done) begin
        case (tag_q.kind)
          RD_PC_LO: pc_lo_q <= mem_rdata;
          RD_PC_HI: pc_hi_q <= mem_rdata;
          RD_FLAGS: flags_q <= mem_rdata[FLAGS_W-1:0];
          RD_POP:   pop_q   <= mem_rdata;
          default:  ;
        endcase
      end
    end
  end

  // The final word is forwarded straight from memory so the pulse lands with its data.
  always_comb begin
    pc_restore    = {pc_hi_q, pc_lo_q};
    flags_restore = flags_q;
    pop_data      = pop_q;
    if (rd_done) begin
      case (tag_q.kind)
        RD_PC_LO: pc_restore[DATA_W-1:0]        = mem_rdata;
        RD_PC_HI: pc_restore[2*DATA_W-1:DATA_W] = mem_rdata;
        RD_FLAGS: flags_restore                 = mem_rdata[FLAGS_W-1:0];
        RD_POP:   pop_data                      = mem_rdata;
        default:  ;
      endcase
    end
  end

  assign pc_restore_vld    = rd_done && tag_q.last;
  assign flags_restore_vld = rd_done && tag_q.last && tag_q.long_seq;
  assign pop_data_vld      = rd_done && (tag_q.kind == RD_POP);

endmodule

// File: tb/tb_stack_mem_sequencer.sv
// Directed self-checking bench for stack_mem_sequencer with a behavioural 1-cycle stack RAM.
module tb_stack_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  seq_state = 2'b00;
  logic [1:0]  seq_op = 2'b00;
  logic        sp_push = 1'b0;
  logic        sp_pop = 1'b0;
  logic [31:0] pc_in = '0;
  logic [3:0]  flags_in = '0;
  logic [15:0] reg_wdata = '0;
  logic [15:0] mem_rdata;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [11:0] sp_out;
  logic [31:0] pc_restore;
  logic        pc_restore_vld;
  logic [3:0]  flags_restore;
  logic        flags_restore_vld;
  logic [15:0] pop_data;
  logic        pop_data_vld;
  logic        stack_fault;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram [0:4095];
  logic [15:0] rdata_q = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) rdata_q <= ram[mem_addr];
  end
  assign mem_rdata = rdata_q;

  stack_mem_sequencer dut (
    .clk(clk), .rst(rst), .seq_state(seq_state), .seq_op(seq_op),
    .sp_push(sp_push), .sp_pop(sp_pop), .pc_in(pc_in), .flags_in(flags_in),
    .reg_wdata(reg_wdata), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .sp_out(sp_out),
    .pc_restore(pc_restore), .pc_restore_vld(pc_restore_vld),
    .flags_restore(flags_restore), .flags_restore_vld(flags_restore_vld),
    .pop_data(pop_data), .pop_data_vld(pop_data_vld), .stack_fault(stack_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (sp_out !== 12'd4095) begin errors++; $display("FAIL reset_sp: got %0d want 4095", sp_out); end
    checks++; if ({mem_we, mem_re} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {mem_we, mem_re}); end
    checks++; if ({pc_restore_vld, flags_restore_vld, pop_data_vld, stack_fault} !== 4'b0000) begin errors++; $display("FAIL reset_valids: got %b want 0000", {pc_restore_vld, flags_restore_vld, pop_data_vld, stack_fault}); end
    checks++; if ({pc_restore, pop_data} !== 48'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {pc_restore, pop_data}); end
  endtask

  task automatic test_call();
    seq_op = 2'b10; pc_in = 32'h0001_2345; seq_state = 2'b10;
    #1;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd4095, 16'h0001}) begin errors++; $display("FAIL call_hi: got we=%b a=%0d d=%h want we=1 a=4095 d=0001", mem_we, mem_addr, mem_wdata); end
    tick();
    seq_state = 2'b01;
    #1;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd4094, 16'h2345}) begin errors++; $display("FAIL call_lo: got we=%b a=%0d d=%h want we=1 a=4094 d=2345", mem_we, mem_addr, mem_wdata); end
    tick();
    seq_state = 2'b00; seq_op = 2'b00;
    #1;
    checks++; if (sp_out !== 12'd4093) begin errors++; $display("FAIL call_sp: got %0d want 4093", sp_out); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL call_idle_we: got %b want 0", mem_we); end
  endtask

  task automatic test_ret();
    seq_op = 2'b11; seq_state = 2'b10;
    #1;
    checks++; if ({mem_re, mem_addr} !== {1'b1, 12'd4094}) begin errors++; $display("FAIL ret_rd1: got re=%b a=%0d want re=1 a=4094", mem_re, mem_addr); end
    tick();
    seq_state = 2'b01;
    #1;
    checks++; if ({mem_re, mem_addr, pc_restore_vld} !== {1'b1, 12'd4095, 1'b0}) begin errors++; $display("FAIL ret_rd2: got re=%b a=%0d vld=%b want re=1 a=4095 vld=0", mem_re, mem_addr, pc_restore_vld); end
    tick();
    seq_state = 2'b00; seq_op = 2'b00;
    #1;
    checks++; if ({pc_restore_vld, flags_restore_vld} !== 2'b10) begin errors++; $display("FAIL ret_vld: got %b want 10", {pc_restore_vld, flags_restore_vld}); end
    checks++; if (pc_restore !== 32'h0001_2345) begin errors++; $display("FAIL ret_pc: got %h want 00012345", pc_restore); end
    checks++; if (sp_out !== 12'd4095) begin errors++; $display("FAIL ret_sp: got %0d want 4095", sp_out); end
    tick();
    checks++; if (pc_restore_vld !== 1'b0) begin errors++; $display("FAIL ret_pulse_len: got %b want 0", pc_restore_vld); end
  endtask

  task automatic test_rti();
    seq_op = 2'b10; pc_in = 32'h1234_5678; flags_in = 4'hA; seq_state = 2'b11;
    #1;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd4095, 16'h000A}) begin errors++; $display("FAIL int_flags: got we=%b a=%0d d=%h want we=1 a=4095 d=000a", mem_we, mem_addr, mem_wdata); end
    tick(); seq_state = 2'b10;
    #1;
    checks++; if (mem_wdata !== 16'h1234) begin errors++; $display("FAIL int_hi: got %h want 1234", mem_wdata); end
    tick(); seq_state = 2'b01;
    tick(); seq_state = 2'b00; seq_op = 2'b00;
    #1;
    checks++; if (sp_out !== 12'd4092) begin errors++; $display("FAIL int_sp: got %0d want 4092", sp_out); end
    tick(); seq_op = 2'b11; seq_state = 2'b11; pc_in = '0; flags_in = '0;
    #1;
    checks++; if ({mem_re, mem_addr} !== {1'b1, 12'd4093}) begin errors++; $display("FAIL rti_rd1: got re=%b a=%0d want re=1 a=4093", mem_re, mem_addr); end
    tick(); seq_state = 2'b10;
    tick(); seq_state = 2'b01;
    #1;
    checks++; if ({pc_restore_vld, flags_restore_vld} !== 2'b00) begin errors++; $display("FAIL rti_early: got %b want 00", {pc_restore_vld, flags_restore_vld}); end
    tick(); seq_state = 2'b00; seq_op = 2'b00;
    #1;
    checks++; if ({pc_restore_vld, flags_restore_vld} !== 2'b11) begin errors++; $display("FAIL rti_vld: got %b want 11", {pc_restore_vld, flags_restore_vld}); end
    checks++; if ({pc_restore, flags_restore} !== {32'h1234_5678, 4'hA}) begin errors++; $display("FAIL rti_data: got pc=%h fl=%h want pc=12345678 fl=a", pc_restore, flags_restore); end
    checks++; if (sp_out !== 12'd4095) begin errors++; $display("FAIL rti_sp: got %0d want 4095", sp_out); end
    tick();
  endtask

  task automatic test_push_pop();
    sp_push = 1'b1; reg_wdata = 16'hBEEF;
    #1;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd4095, 16'hBEEF}) begin errors++; $display("FAIL push_wr: got we=%b a=%0d d=%h want we=1 a=4095 d=beef", mem_we, mem_addr, mem_wdata); end
    tick(); sp_push = 1'b0; sp_pop = 1'b1; reg_wdata = '0;
    #1;
    checks++; if ({mem_re, mem_addr, pop_data_vld} !== {1'b1, 12'd4095, 1'b0}) begin errors++; $display("FAIL pop_rd: got re=%b a=%0d vld=%b want re=1 a=4095 vld=0", mem_re, mem_addr, pop_data_vld); end
    tick(); sp_pop = 1'b0;
    #1;
    checks++; if ({pop_data_vld, pop_data} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL pop_data: got vld=%b d=%h want vld=1 d=beef", pop_data_vld, pop_data); end
    checks++; if (sp_out !== 12'd4095) begin errors++; $display("FAIL pop_sp: got %0d want 4095", sp_out); end
    tick();
    checks++; if (pop_data_vld !== 1'b0) begin errors++; $display("FAIL pop_pulse_len: got %b want 0", pop_data_vld); end
  endtask

  task automatic test_conflict();
    sp_push = 1'b1; sp_pop = 1'b1;
    #1;
    checks++; if ({mem_we, mem_re} !== 2'b00) begin errors++; $display("FAIL both_strobes: got %b want 00", {mem_we, mem_re}); end
    tick(); sp_pop = 1'b0; reg_wdata = 16'h1111;
    seq_op = 2'b10; seq_state = 2'b10; pc_in = 32'hAAAA_5555;
    #1;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd4095, 16'hAAAA}) begin errors++; $display("FAIL seq_over_push: got we=%b a=%0d d=%h want we=1 a=4095 d=aaaa", mem_we, mem_addr, mem_wdata); end
    tick(); seq_state = 2'b01; sp_push = 1'b0;
    tick(); seq_state = 2'b00; seq_op = 2'b00;
    #1;
    checks++; if (sp_out !== 12'd4093) begin errors++; $display("FAIL conflict_sp: got %0d want 4093", sp_out); end
    tick(); seq_op = 2'b11; seq_state = 2'b10; rst = 1'b1;
    tick(); rst = 1'b0; seq_state = 2'b01;
    #1;
    checks++; if ({mem_re, sp_out} !== {1'b0, 12'd4095}) begin errors++; $display("FAIL rst_abort: got re=%b sp=%0d want re=0 sp=4095", mem_re, sp_out); end
    tick(); seq_state = 2'b00; seq_op = 2'b00;
    #1;
    checks++; if (pc_restore_vld !== 1'b0) begin errors++; $display("FAIL rst_no_pulse: got %b want 0", pc_restore_vld); end
    tick();
    checks++; if ({pc_restore_vld, sp_out} !== {1'b0, 12'd4095}) begin errors++; $display("FAIL rst_no_pulse2: got vld=%b sp=%0d want vld=0 sp=4095", pc_restore_vld, sp_out); end
  endtask

  task automatic test_illegal();
    seq_op = 2'b10; seq_state = 2'b01; pc_in = 32'hCAFE_F00D;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL illegal_01_we: got %b want 0", mem_we); end
    tick(); seq_op = 2'b00; seq_state = 2'b10;
    #1;
    checks++; if ({mem_we, mem_re} !== 2'b00) begin errors++; $display("FAIL op_none_slot: got %b want 00", {mem_we, mem_re}); end
    tick(); seq_state = 2'b01;
    tick(); seq_state = 2'b00; pc_in = '0;
    #1;
    checks++; if (sp_out !== 12'd4095) begin errors++; $display("FAIL illegal_sp: got %0d want 4095", sp_out); end
  endtask

  task automatic test_bounds();
    sp_pop = 1'b1;
    #1;
`ifdef STACK_BOUNDS_CHECK_EN
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL bound_re: got %b want 0", mem_re); end
    tick(); sp_pop = 1'b0;
    #1;
    checks++; if ({stack_fault, sp_out, pop_data_vld} !== {1'b1, 12'd4095, 1'b0}) begin errors++; $display("FAIL bound_fault: got f=%b sp=%0d vld=%b want f=1 sp=4095 vld=0", stack_fault, sp_out, pop_data_vld); end
    tick();
    checks++; if (stack_fault !== 1'b1) begin errors++; $display("FAIL bound_sticky: got %b want 1", stack_fault); end
`else
    checks++; if ({mem_re, mem_addr} !== {1'b1, 12'd0}) begin errors++; $display("FAIL wrap_rd: got re=%b a=%0d want re=1 a=0", mem_re, mem_addr); end
    tick(); sp_pop = 1'b0;
    #1;
    checks++; if ({sp_out, stack_fault} !== {12'd0, 1'b0}) begin errors++; $display("FAIL wrap_sp: got sp=%0d f=%b want sp=0 f=0", sp_out, stack_fault); end
    sp_push = 1'b1; reg_wdata = 16'h0042;
    #1;
    checks++; if ({mem_we, mem_addr} !== {1'b1, 12'd0}) begin errors++; $display("FAIL wrap_push: got we=%b a=%0d want we=1 a=0", mem_we, mem_addr); end
    tick(); sp_push = 1'b0;
    #1;
    checks++; if (sp_out !== 12'd4095) begin errors++; $display("FAIL wrap_back: got %0d want 4095", sp_out); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    test_reset();
    test_call();
    test_ret();
    test_rti();
    test_push_pop();
    test_conflict();
    test_illegal();
    test_bounds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
